bnn_maxpool2d_stream: RTL and testbench
=======================================

# bnn_maxpool2d_stream

Streaming binary 2-D pooling stage for the BNN datapath. It accepts one pixel per beat in raster order, carrying all channels in parallel. Each POOL_SIZE x POOL_SIZE non-overlapping window is reduced per channel with OR (max) or AND (min). Partial window results are held in a one-row accumulator, so no frame buffer is needed. It sits between a binary conv/threshold stage and the next layer, with valid/ready handshakes on both sides.

## Interface
- NUM_CHANNELS, 3: channel bits per pixel beat.
- IMG_WIDTH, 28: input pixels per row.
- IMG_HEIGHT, 28: input rows per frame.
- POOL_SIZE, 2: window edge; stride equals POOL_SIZE. Legal range is 2 to min(IMG_WIDTH, IMG_HEIGHT).
- MODE, POOL_MAX: selects the reduction. POOL_MAX is per-channel OR; POOL_MIN is per-channel AND.
- OUT_W / OUT_H (derived): IMG_WIDTH/POOL_SIZE and IMG_HEIGHT/POOL_SIZE, both floor division.

Ports:
- clk  in  1  sole clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  block can accept a pixel.
- in_pixel  in  NUM_CHANNELS  bit c is channel c.
- out_valid  out  1  pooled pixel valid.
- out_ready  in  1  downstream accepts the pooled pixel.
- out_pixel  out  NUM_CHANNELS  pooled result, bit c is channel c.
- out_last  out  1  set with the final pooled pixel of a frame.

## Operation
- Input is accepted when in_valid && in_ready.
- Counters col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1) advance on every accept.
  - col wraps to 0 and row increments.
  - At the last pixel of a frame, both counters wrap to 0 and the next frame follows with no gap.
- Window coordinates: wc = col / POOL_SIZE; rr = row mod POOL_SIZE; cc = col mod POOL_SIZE.
- Ragged edge: a pixel with col >= OUT_W*POOL_SIZE or row >= OUT_H*POOL_SIZE is accepted and discarded.
- Accumulator acc[0..OUT_W-1], NUM_CHANNELS bits per entry:
  - rr==0 && cc==0: acc[wc] <= in_pixel. Window start overwrites, so no stale data carries over and AND mode needs no preset.
  - Any other in-range pixel: acc[wc] <= acc[wc] OP in_pixel.
- A window completes on an accepted in-range pixel with rr==POOL_SIZE-1 and cc==POOL_SIZE-1.
  - out_pixel <= acc[wc] OP in_pixel; out_valid <= 1.
  - out_last <= (row/POOL_SIZE == OUT_H-1) && (wc == OUT_W-1).
- Output order is raster over (OUT_H, OUT_W); exactly OUT_W*OUT_H results per frame.
- Output register clears: out_valid && out_ready with no new completion sets out_valid to 0.

## Timing
- Reset values: out_valid=0, out_pixel=0, out_last=0, col=row=0, acc all 0.
- in_ready = !out_valid || out_ready (combinational). There is no skid buffer.
- Latency: out_valid rises the cycle after the completing pixel is accepted.
- Throughput: 1 pixel/cycle sustained while out_ready=1.
- Simultaneous drain and fill: if out_ready=1 with a new completion in the same cycle, the register reloads and out_valid stays 1 with no bubble.
- Backpressure: out_valid=1 with out_ready=0 forces in_ready=0. out_pixel and out_last stay stable until taken.
- in_valid=0 stalls all counters; the accumulator holds.
- Reset mid-frame: everything returns to reset values. The next accepted pixel is treated as (0,0) of a new frame and the partial output is dropped.
- No combinational path from in_valid or in_pixel to out_*.

## Structure
- Shared package bnn_pkg:
  - typedef enum pool_mode_e {POOL_MAX, POOL_MIN}.
  - Function clog2_min1 for counter widths, always at least 1 bit.
- Sub-module bnn_raster_counter: col/row counters with wrap, window coordinates, in-range and complete/last flags. It is reused by future streaming conv stages.
- The top holds the accumulator array, the reduce operator (a generate on MODE) and the output register.
- Elaboration assertions: POOL_SIZE >= 2; OUT_W >= 1; OUT_H >= 1.

## Test plan
- Max, 4x4, 1 channel, P=2: all zeros except pixel (1,1)=1 -> outputs 1,0,0,0, with out_last on the 4th only.
- Min, same geometry: all ones except pixel (0,3)=0 -> outputs 1,0,1,1.
- Ragged 5x5, P=2, max: ones only in row 4 and col 4 -> 25 beats accepted, 4 outputs all 0, out_last on the 4th.
- 3 channels, 4x4, P=2: each channel carries a distinct single-hot pattern -> per-bit results independent. Two back-to-back frames give 8 outputs and 2 out_last pulses.
- Backpressure: out_ready held low 5 cycles after the first output -> in_ready=0 and out_pixel stable throughout. Random in_valid/out_ready over 100 frames matches the reference model with no loss or duplication.
- Reset: assert rst after 7 pixels of a frame -> out_valid=0 immediately. The next full frame produces correct outputs starting at (0,0).

Source files
------------

// File: rtl/bnn_pkg.sv
// Shared types and helpers for the BNN streaming datapath.
package bnn_pkg;

    typedef enum logic [0:0] {
        POOL_MAX,
        POOL_MIN
    } pool_mode_e;

    // Bits needed to count 0..n-1, never fewer than one.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bnn_raster_counter.sv
// Raster-order position tracker for streaming window stages: col/row with frame wrap, plus
// window column/row indices and in-window offsets kept as counters rather than divides.
module bnn_raster_counter
    import bnn_pkg::*;
#(
    parameter int unsigned IMG_WIDTH  = 28,
    parameter int unsigned IMG_HEIGHT = 28,
    parameter int unsigned POOL_SIZE  = 2,
    localparam int unsigned WC_W      = clog2_min1((IMG_WIDTH - 1) / POOL_SIZE + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            advance,
    output logic [WC_W-1:0] wc,
    output logic            in_range,
    output logic            win_start,
    output logic            win_done,
    output logic            frame_last
);

    localparam int unsigned OUT_W = IMG_WIDTH / POOL_SIZE;
    localparam int unsigned OUT_H = IMG_HEIGHT / POOL_SIZE;
    localparam int unsigned COL_W = clog2_min1(IMG_WIDTH);
    localparam int unsigned ROW_W = clog2_min1(IMG_HEIGHT);
    localparam int unsigned POS_W = clog2_min1(POOL_SIZE);
    localparam int unsigned WR_W  = clog2_min1((IMG_HEIGHT - 1) / POOL_SIZE + 1);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(POOL_SIZE - 1);
    localparam logic [WC_W-1:0]  WC_LAST  = WC_W'(OUT_W - 1);
    localparam logic [WR_W-1:0]  WR_LAST  = WR_W'(OUT_H - 1);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [POS_W-1:0] cc_q, cc_d, rr_q, rr_d;
    logic [WC_W-1:0]  wc_q, wc_d;
    logic [WR_W-1:0]  wr_q, wr_d;

    // Next position: step the column, wrapping into the next row and then the next frame.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        cc_d  = cc_q;
        rr_d  = rr_q;
        wc_d  = wc_q;
        wr_d  = wr_q;
        if (advance) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                cc_d  = '0;
                wc_d  = '0;
                if (row_q == ROW_LAST) begin
                    row_d = '0;
                    rr_d  = '0;
                    wr_d  = '0;
                end else begin
                    row_d = row_q + 1'b1;
                    if (rr_q == POS_LAST) begin
                        rr_d = '0;
                        wr_d = wr_q + 1'b1;
                    end else begin
                        rr_d = rr_q + 1'b1;
                    end
                end
            end else begin
                col_d = col_q + 1'b1;
                if (cc_q == POS_LAST) begin
                    cc_d = '0;
                    wc_d = wc_q + 1'b1;
                end else begin
                    cc_d = cc_q + 1'b1;
                end
            end
        end
    end

    // Position registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
            cc_q  <= '0;
            rr_q  <= '0;
            wc_q  <= '0;
            wr_q  <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            cc_q  <= cc_d;
            rr_q  <= rr_d;
            wc_q  <= wc_d;
            wr_q  <= wr_d;
        end
    end

    // Pixels past the last whole window column/row fall outside every window.
    assign in_range   = (32'(wc_q) < OUT_W) && (32'(wr_q) < OUT_H);
    assign win_start  = in_range && (cc_q == '0) && (rr_q == '0);
    assign win_done   = in_range && (cc_q == POS_LAST) && (rr_q == POS_LAST);
    assign frame_last = (wc_q == WC_LAST) && (wr_q == WR_LAST);
    assign wc         = wc_q;

endmodule

// File: rtl/bnn_maxpool2d_stream.sv
// Streaming binary max/min pooling: a one-row accumulator of partial windows feeding a single
// registered output stage with valid/ready handshakes.
module bnn_maxpool2d_stream
    import bnn_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS = 3,
    parameter int unsigned IMG_WIDTH    = 28,
    parameter int unsigned IMG_HEIGHT   = 28,
    parameter int unsigned POOL_SIZE    = 2,
    parameter pool_mode_e  MODE         = POOL_MAX
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_CHANNELS-1:0] in_pixel,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NUM_CHANNELS-1:0] out_pixel,
    output logic                    out_last
);

    localparam int unsigned OUT_W = IMG_WIDTH / POOL_SIZE;
    localparam int unsigned OUT_H = IMG_HEIGHT / POOL_SIZE;
    // One slot per window column, including a ragged partial column that is never written, so
    // the counter's column index addresses the array without truncation.
    localparam int unsigned ACC_DEPTH = (IMG_WIDTH - 1) / POOL_SIZE + 1;
    localparam int unsigned WC_W      = clog2_min1(ACC_DEPTH);

    if (POOL_SIZE < 2) begin : g_chk_pool
        $error("POOL_SIZE must be at least 2");
    end
    if (OUT_W < 1) begin : g_chk_out_w
        $error("IMG_WIDTH must hold at least one window");
    end
    if (OUT_H < 1) begin : g_chk_out_h
        $error("IMG_HEIGHT must hold at least one window");
    end

    logic                    accept;
    logic                    in_range, win_start, win_done, frame_last;
    logic [WC_W-1:0]         wc;
    logic [NUM_CHANNELS-1:0] acc_q [ACC_DEPTH];
    logic [NUM_CHANNELS-1:0] acc_sel, reduced;
    logic                    out_valid_q, out_last_q;
    logic [NUM_CHANNELS-1:0] out_pixel_q;

    // No skid buffer: a held result blocks the input.
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    bnn_raster_counter #(
        .IMG_WIDTH  (IMG_WIDTH),
        .IMG_HEIGHT (IMG_HEIGHT),
        .POOL_SIZE  (POOL_SIZE)
    ) u_counter (
        .clk        (clk),
        .rst        (rst),
        .advance    (accept),
        .wc         (wc),
        .in_range   (in_range),
        .win_start  (win_start),
        .win_done   (win_done),
        .frame_last (frame_last)
    );

    assign acc_sel = acc_q[wc];

    if (MODE == POOL_MAX) begin : g_or
        assign reduced = acc_sel | in_pixel;
    end else begin : g_and
        assign reduced = acc_sel & in_pixel;
    end

    // Accumulate partial windows; the first pixel of a window overwrites stale contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ACC_DEPTH; i++) begin
                acc_q[i] <= '0;
            end
        end else if (accept && in_range) begin
            acc_q[wc] <= win_start ? in_pixel : reduced;
        end
    end

    // Output register: a completion (re)loads it, a drain without completion empties it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_pixel_q <= '0;
            out_last_q  <= 1'b0;
        end else if (accept && win_done) begin
            out_valid_q <= 1'b1;
            out_pixel_q <= reduced;
            out_last_q  <= frame_last;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_pixel = out_pixel_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_bnn_maxpool2d_stream.sv
// Bench for bnn_maxpool2d_stream: four geometries/modes checked cycle by cycle against a
// frame-image reference model, plus directed patterns, backpressure and mid-frame reset.
module tb_bnn_maxpool2d_stream;
    import bnn_pkg::*;

    localparam int ND   = 4;
    localparam int LOGN = 1024;
    localparam int GW   [ND] = '{4, 4, 5, 7};
    localparam int GH   [ND] = '{4, 4, 5, 6};
    localparam int GP   [ND] = '{2, 2, 2, 3};
    localparam int GMIN [ND] = '{0, 1, 0, 1};

    logic                clk = 1'b0;
    logic                rst;
    logic [ND-1:0]       in_valid, in_ready, out_valid, out_ready, out_last;
    logic [ND-1:0][2:0]  in_pixel, out_pixel;

    int errors = 0;
    int checks = 0;

    // reference model state
    logic [2:0] img [ND][8][8];
    int         mcol [ND];
    int         mrow [ND];
    logic       exp_valid [ND];
    logic [2:0] exp_pix [ND];
    logic       exp_last [ND];

    // log of handshaken outputs as observed on the ports
    logic [2:0] log_pix [ND][LOGN];
    logic       log_last [ND][LOGN];
    int         log_n [ND];

    logic [2:0] pat [ND][64];
    logic [2:0] ep [4];
    logic       el [4];

    always #5 clk = ~clk;

    bnn_maxpool2d_stream #(.NUM_CHANNELS(3), .IMG_WIDTH(4), .IMG_HEIGHT(4), .POOL_SIZE(2),
                           .MODE(POOL_MAX)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_pixel(in_pixel[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_pixel(out_pixel[0]), .out_last(out_last[0]));
    bnn_maxpool2d_stream #(.NUM_CHANNELS(3), .IMG_WIDTH(4), .IMG_HEIGHT(4), .POOL_SIZE(2),
                           .MODE(POOL_MIN)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_pixel(in_pixel[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_pixel(out_pixel[1]), .out_last(out_last[1]));
    bnn_maxpool2d_stream #(.NUM_CHANNELS(3), .IMG_WIDTH(5), .IMG_HEIGHT(5), .POOL_SIZE(2),
                           .MODE(POOL_MAX)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_pixel(in_pixel[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_pixel(out_pixel[2]), .out_last(out_last[2]));
    bnn_maxpool2d_stream #(.NUM_CHANNELS(3), .IMG_WIDTH(7), .IMG_HEIGHT(6), .POOL_SIZE(3),
                           .MODE(POOL_MIN)) u_dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
        .in_pixel(in_pixel[3]), .out_valid(out_valid[3]), .out_ready(out_ready[3]),
        .out_pixel(out_pixel[3]), .out_last(out_last[3]));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", tag, got, want);
        end
    endtask

    // OR/AND over the stored window, straight from the frame image.
    function automatic logic [2:0] win_reduce(input int d, input int wr, input int wc);
        logic [2:0] r;
        r = (GMIN[d] != 0) ? 3'b111 : 3'b000;
        for (int i = 0; i < GP[d]; i++) begin
            for (int j = 0; j < GP[d]; j++) begin
                if (GMIN[d] != 0) r = r & img[d][wr * GP[d] + i][wc * GP[d] + j];
                else              r = r | img[d][wr * GP[d] + i][wc * GP[d] + j];
            end
        end
        return r;
    endfunction

    // Sample mid-cycle: compare ports with the model, then advance the model for the coming edge.
    always @(negedge clk) begin
        int  ow, oh, p;
        bit  rdy;
        if (rst) begin
            for (int d = 0; d < ND; d++) begin
                mcol[d]      = 0;
                mrow[d]      = 0;
                exp_valid[d] = 1'b0;
                exp_pix[d]   = 3'b000;
                exp_last[d]  = 1'b0;
            end
        end else begin
            for (int d = 0; d < ND; d++) begin
                p  = GP[d];
                ow = GW[d] / p;
                oh = GH[d] / p;
                check_eq($sformatf("d%0d out_valid", d), 32'(out_valid[d]), 32'(exp_valid[d]));
                if (exp_valid[d]) begin
                    check_eq($sformatf("d%0d out_pixel", d), 32'(out_pixel[d]), 32'(exp_pix[d]));
                    check_eq($sformatf("d%0d out_last", d), 32'(out_last[d]), 32'(exp_last[d]));
                end
                rdy = !exp_valid[d] || out_ready[d];
                check_eq($sformatf("d%0d in_ready", d), 32'(in_ready[d]), 32'(rdy));
                if (out_valid[d] && out_ready[d]) begin
                    if (log_n[d] < LOGN) begin
                        log_pix[d][log_n[d]]  = out_pixel[d];
                        log_last[d][log_n[d]] = out_last[d];
                    end
                    log_n[d]++;
                end
                if (exp_valid[d] && out_ready[d]) exp_valid[d] = 1'b0;
                if (in_valid[d] && rdy) begin
                    img[d][mrow[d]][mcol[d]] = in_pixel[d];
                    if ((mrow[d] % p == p - 1) && (mcol[d] % p == p - 1) &&
                        (mrow[d] < oh * p) && (mcol[d] < ow * p)) begin
                        exp_valid[d] = 1'b1;
                        exp_pix[d]   = win_reduce(d, mrow[d] / p, mcol[d] / p);
                        exp_last[d]  = (mrow[d] / p == oh - 1) && (mcol[d] / p == ow - 1);
                    end
                    mcol[d]++;
                    if (mcol[d] == GW[d]) begin
                        mcol[d] = 0;
                        mrow[d]++;
                        if (mrow[d] == GH[d]) mrow[d] = 0;
                    end
                end
            end
        end
    end

    // Present one pixel (called at posedge+1) and hold it until it is taken.
    task automatic send_beat(input int d, input logic [2:0] v);
        int n;
        bit rdy;
        bit taken;
        in_valid[d] = 1'b1;
        in_pixel[d] = v;
        n = 0;
        taken = 1'b0;
        while (!taken) begin
            @(negedge clk);
            rdy = in_ready[d];
            @(posedge clk);
            #1;
            if (rdy) taken = 1'b1;
            else begin
                n++;
                if (n > 300) begin
                    check_eq($sformatf("d%0d accept wait", d), 32'(rdy), 32'd1);
                    taken = 1'b1;
                end
            end
        end
    endtask

    task automatic send_frame(input int d);
        for (int i = 0; i < GW[d] * GH[d]; i++) send_beat(d, pat[d][i]);
    endtask

    task automatic fill_pat(input int d, input logic [2:0] v);
        for (int i = 0; i < 64; i++) pat[d][i] = v;
    endtask

    // Wait for the expected output count, then confirm no extra outputs follow.
    task automatic wait_outs(input int d, input int target);
        int n;
        n = 0;
        while (log_n[d] < target && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
        check_eq($sformatf("d%0d output count", d), 32'(log_n[d]), 32'(target));
    endtask

    task automatic check_log(input int d, input int start, input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            check_eq($sformatf("%s pix[%0d]", tag, k), 32'(log_pix[d][start + k]), 32'(ep[k % 4]));
            check_eq($sformatf("%s last[%0d]", tag, k), 32'(log_last[d][start + k]),
                     32'(el[k % 4]));
        end
    endtask

    task automatic send_rand_frame(input int d);
        logic [2:0] v;
        for (int i = 0; i < GW[d] * GH[d]; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid[d] = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            // bias bits so windows are not almost always saturated
            if (GMIN[d] != 0) v = 3'($urandom | $urandom);
            else              v = 3'($urandom & $urandom);
            send_beat(d, v);
        end
    endtask

    task automatic run_random(input int d);
        bit done;
        done = 1'b0;
        fork
            begin
                for (int f = 0; f < 100; f++) send_rand_frame(d);
                in_valid[d] = 1'b0;
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready[d] = ($urandom_range(0, 2) != 0);
                end
                out_ready[d] = 1'b1;
            end
        join
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int         start, n;
        int         base [ND];
        logic [2:0] held;

        rst       = 1'b1;
        in_valid  = '0;
        in_pixel  = '0;
        out_ready = '1;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < ND; d++) begin
            check_eq($sformatf("d%0d reset out_valid", d), 32'(out_valid[d]), 32'd0);
            check_eq($sformatf("d%0d reset out_pixel", d), 32'(out_pixel[d]), 32'd0);
            check_eq($sformatf("d%0d reset out_last", d), 32'(out_last[d]), 32'd0);
            check_eq($sformatf("d%0d reset in_ready", d), 32'(in_ready[d]), 32'd1);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;

        // max: single one at (1,1)
        fill_pat(0, 3'b000);
        pat[0][5] = 3'b001;
        start = log_n[0];
        send_frame(0);
        in_valid[0] = 1'b0;
        wait_outs(0, start + 4);
        ep = '{3'd1, 3'd0, 3'd0, 3'd0};
        el = '{1'b0, 1'b0, 1'b0, 1'b1};
        check_log(0, start, 4, "max_hot");

        // min: single zero at (0,3) on channel 0
        fill_pat(1, 3'b111);
        pat[1][3] = 3'b110;
        start = log_n[1];
        send_frame(1);
        in_valid[1] = 1'b0;
        wait_outs(1, start + 4);
        ep = '{3'd7, 3'd6, 3'd7, 3'd7};
        check_log(1, start, 4, "min_cold");

        // ragged 5x5: ones only in the discarded row 4 / col 4
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                pat[2][r * 5 + c] = (r == 4 || c == 4) ? 3'b111 : 3'b000;
        start = log_n[2];
        send_frame(2);
        in_valid[2] = 1'b0;
        wait_outs(2, start + 4);
        ep = '{3'd0, 3'd0, 3'd0, 3'd0};
        check_log(2, start, 4, "ragged");

        // independent channels, two frames back to back
        fill_pat(0, 3'b000);
        pat[0][0]  = 3'b001;
        pat[0][11] = 3'b010;
        pat[0][12] = 3'b100;
        start = log_n[0];
        send_frame(0);
        send_frame(0);
        in_valid[0] = 1'b0;
        wait_outs(0, start + 8);
        ep = '{3'd1, 3'd0, 3'd4, 3'd2};
        check_log(0, start, 8, "channels");

        // backpressure: hold the first result for five cycles
        start = log_n[0];
        fork
            begin
                send_frame(0);
                in_valid[0] = 1'b0;
            end
            begin
                n = 0;
                while (!out_valid[0] && n < 100) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                check_eq("bp first out_valid", 32'(out_valid[0]), 32'd1);
                out_ready[0] = 1'b0;
                held = out_pixel[0];
                check_eq("bp first pixel", 32'(held), 32'd1);
                repeat (5) begin
                    @(posedge clk);
                    #1;
                    check_eq("bp in_ready", 32'(in_ready[0]), 32'd0);
                    check_eq("bp out_valid", 32'(out_valid[0]), 32'd1);
                    check_eq("bp out_pixel stable", 32'(out_pixel[0]), 32'(held));
                end
                out_ready[0] = 1'b1;
            end
        join
        wait_outs(0, start + 4);
        check_log(0, start, 4, "bp");

        // reset after 7 pixels, with a completed window pending
        fill_pat(2, 3'b101);
        for (int i = 0; i < 7; i++) send_beat(2, pat[2][i]);
        in_valid[2] = 1'b0;
        check_eq("pre-reset out_valid", 32'(out_valid[2]), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("mid reset out_valid", 32'(out_valid[2]), 32'd0);
        check_eq("mid reset out_pixel", 32'(out_pixel[2]), 32'd0);
        check_eq("mid reset out_last", 32'(out_last[2]), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        fill_pat(2, 3'b000);
        pat[2][5]  = 3'b001;
        pat[2][18] = 3'b001;
        start = log_n[2];
        send_frame(2);
        in_valid[2] = 1'b0;
        wait_outs(2, start + 4);
        ep = '{3'd1, 3'd0, 3'd0, 3'd1};
        check_log(2, start, 4, "after_reset");

        // random valid/ready, 100 frames on every configuration in parallel
        for (int d = 0; d < ND; d++) base[d] = log_n[d];
        fork
            run_random(0);
            run_random(1);
            run_random(2);
            run_random(3);
        join
        repeat (10) @(posedge clk);
        #1;
        for (int d = 0; d < ND; d++) begin
            check_eq($sformatf("d%0d random output count", d), 32'(log_n[d] - base[d]),
                     32'(100 * (GW[d] / GP[d]) * (GH[d] / GP[d])));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
